// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the CPU pipeline stages: fetch FSM encodings, instruction
// geometry, the default boot address and the fetch-queue entry layout.
package instr_fetch_unit_pkg;

  localparam int          INSTR_W          = 32;
  localparam int          OPCODE_MSB       = 31;
  localparam int          OPCODE_LSB       = 26;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory port, decoder handshake and branch redirect.
// Signal suffixes give the direction as seen from the fetch unit (master).
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic               imem_req_o;
  logic [31:0]        imem_addr_o;
  logic               imem_rvalid_i;
  logic [INSTR_W-1:0] imem_rdata_i;
  logic               instr_valid_o;
  logic               instr_ready_i;
  logic [INSTR_W-1:0] instr_o;
  logic [31:0]        pc_o;
  logic [31:0]        pc_plus4_o;
  logic               redirect_i;
  logic [31:0]        redirect_pc_i;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
    input  imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
    output imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Shift-style queue of {pc, instr}; entry 0 is always the head, so the head is a
// plain register and keeps its last value once the queue drains.
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t push_data_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o,
  output logic [31:0]  head_next_pc_o
);

  fetch_entry_t  ent_q [DEPTH];
  fetch_entry_t  ent_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] keep;
  logic          do_pop;

  assign do_pop = pop_i && (count_q != '0);
  assign keep   = count_q - CW'(do_pop);

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    ent_d   = ent_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_pop && (CW'(i) < keep)) begin
          ent_d[i] = ent_q[(i + 1) % DEPTH];
        end else if (push_i && (CW'(i) == keep)) begin
          ent_d[i] = push_data_i;
        end
      end
      count_d = keep + CW'(push_i);
    end
  end

  // NOTE: the storage is reset too, because the head feeds outputs that must read 0 out of reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  assign count_o        = count_q;
  assign head_o         = ent_q[0];
  assign head_next_pc_o = ent_d[0].pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps at most one instruction-memory read in flight,
// credit-gates issue against the queue and drops wrong-path responses on redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  instr_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   pc_plus4_q;
  logic          run_q;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  logic [31:0]   head_next_pc;
  logic [CW:0]   occupancy;
  logic          pop, issue, push, can_issue;

  assign pop = bus.instr_valid_o && bus.instr_ready_i;

  // A word returning this cycle is still counted as outstanding: it lands in the queue.
  assign occupancy = {1'b0, count} + (CW+1)'(state_q != S_FETCH) - (CW+1)'(pop);
  assign can_issue = (state_q == S_FETCH) || ((state_q == S_WAIT) && bus.imem_rvalid_i);
  assign issue     = run_q && can_issue && !bus.redirect_i && (occupancy < (CW+1)'(DEPTH));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;

    if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end

    case (state_q)
      S_FETCH: if (issue) state_d = S_WAIT;
      S_WAIT: begin
        if (bus.redirect_i) begin
          state_d = bus.imem_rvalid_i ? S_FETCH : S_DROP;
        end else if (bus.imem_rvalid_i) begin
          push    = 1'b1;
          state_d = issue ? S_WAIT : S_FETCH;
        end
      end
      S_DROP:  if (bus.imem_rvalid_i) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase

    if (bus.redirect_i) fetch_pc_d = bus.redirect_pc_i & 32'hFFFF_FFFC;
  end

  // run_q holds off the first request until one clock after reset releases,
  // so imem_req_o reads 0 throughout reset even though the state is S_FETCH.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC & 32'hFFFF_FFFC;
      req_pc_q   <= '0;
      pc_plus4_q <= 32'd4;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pc_plus4_q <= head_next_pc + 32'd4;
      run_q      <= 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .push_i         (push),
    .pop_i          (pop),
    .flush_i        (bus.redirect_i),
    .push_data_i    ('{pc: req_pc_q, instr: bus.imem_rdata_i}),
    .count_o        (count),
    .head_o         (head),
    .head_next_pc_o (head_next_pc)
  );

  assign bus.imem_req_o    = issue;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = (count != '0);
  assign bus.instr_o       = head.instr;
  assign bus.pc_o          = head.pc;
  assign bus.pc_plus4_o    = pc_plus4_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table for boot, backpressure
// and redirect-while-outstanding, plus hand sequences for the remaining corner cases.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rst;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hAC00_0000 ^ a;
  endfunction

  function automatic vec_t mk(input string name, input bit rst, input logic rv,
                              input logic [31:0] rdata, input logic rdy, input logic redir,
                              input logic [31:0] rpc, input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_instr);
    vec_t v;
    v.name = name; v.rst = rst; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
    v.redir = redir; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic drive(input logic rv, input logic [31:0] rdata, input logic rdy,
                       input logic redir, input logic [31:0] rpc);
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rdata;
    bus.instr_ready_i = rdy;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    #1;
  endtask

  // Leaves the bench at the falling edge where reset releases.
  task automatic do_reset();
    @(negedge clk);
    bus.imem_rvalid_i = 1'b0;
    bus.redirect_i    = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.instr_ready_i = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;

    // Boot, 1-cycle memory, consumer always ready.
    vecs.push_back(mk("boot_idle", 1, 0, 0,       1, 0, 0, 0, 0,     0, 0,     0));
    vecs.push_back(mk("boot_c0",   0, 0, 0,       1, 0, 0, 1, 32'h0, 0, 0,     0));
    vecs.push_back(mk("boot_c1",   0, 1, w(0),    1, 0, 0, 1, 32'h4, 0, 0,     0));
    vecs.push_back(mk("boot_c2",   0, 1, w(4),    1, 0, 0, 1, 32'h8, 1, 32'h0, w(0)));
    vecs.push_back(mk("boot_c3",   0, 1, w(8),    1, 0, 0, 1, 32'hC, 1, 32'h4, w(4)));
    vecs.push_back(mk("boot_c4",   0, 1, w(12),   1, 0, 0, 1, 32'h10,1, 32'h8, w(8)));
    vecs.push_back(mk("boot_c5",   0, 1, w(16),   1, 0, 0, 1, 32'h14,1, 32'hC, w(12)));
    // Backpressure: consumer stalls, exactly two words buffered.
    vecs.push_back(mk("bp_idle",   1, 0, 0,       0, 0, 0, 0, 0,     0, 0,     0));
    vecs.push_back(mk("bp_0",      0, 0, 0,       0, 0, 0, 1, 32'h0, 0, 0,     0));
    vecs.push_back(mk("bp_1",      0, 1, w(0),    0, 0, 0, 1, 32'h4, 0, 0,     0));
    vecs.push_back(mk("bp_2",      0, 1, w(4),    0, 0, 0, 0, 0,     1, 32'h0, w(0)));
    vecs.push_back(mk("bp_3",      0, 0, 0,       0, 0, 0, 0, 0,     1, 32'h0, w(0)));
    vecs.push_back(mk("bp_4",      0, 0, 0,       0, 0, 0, 0, 0,     1, 32'h0, w(0)));
    vecs.push_back(mk("bp_5",      0, 0, 0,       0, 0, 0, 0, 0,     1, 32'h0, w(0)));
    vecs.push_back(mk("bp_6",      0, 0, 0,       1, 0, 0, 1, 32'h8, 1, 32'h0, w(0)));
    vecs.push_back(mk("bp_7",      0, 1, w(8),    1, 0, 0, 1, 32'hC, 1, 32'h4, w(4)));
    vecs.push_back(mk("bp_8",      0, 0, 0,       1, 0, 0, 0, 0,     1, 32'h8, w(8)));
    vecs.push_back(mk("bp_9",      0, 1, w(12),   1, 0, 0, 1, 32'h10,0, 32'h8, w(8)));
    vecs.push_back(mk("bp_10",     0, 0, 0,       1, 0, 0, 0, 0,     1, 32'hC, w(12)));
    // Redirect to 0x40 while a 3-cycle read is in flight.
    vecs.push_back(mk("rd_idle",   1, 0, 0,       1, 0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(mk("rd_0",      0, 0, 0,       1, 0, 0,     1, 32'h0, 0, 0,     0));
    vecs.push_back(mk("rd_1",      0, 0, 0,       1, 1, 32'h40,0, 0,     0, 0,     0));
    vecs.push_back(mk("rd_2",      0, 0, 0,       1, 0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(mk("rd_3",      0, 1, w(0),    1, 0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(mk("rd_4",      0, 0, 0,       1, 0, 0,     1, 32'h40,0, 0,     0));
    vecs.push_back(mk("rd_5",      0, 0, 0,       1, 0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(mk("rd_6",      0, 0, 0,       1, 0, 0,     0, 0,     0, 0,     0));
    vecs.push_back(mk("rd_7",      0, 1, w(32'h40),1,0, 0,     1, 32'h44,0, 0,     0));
    vecs.push_back(mk("rd_8",      0, 0, 0,       1, 0, 0,     0, 0,     1, 32'h40,w(32'h40)));

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      else @(negedge clk);
      drive(vecs[k].rv, vecs[k].rdata, vecs[k].rdy, vecs[k].redir, vecs[k].rpc);
      check({vecs[k].name, " req"}, 32'(bus.imem_req_o), 32'(vecs[k].e_req));
      if (vecs[k].e_req) check({vecs[k].name, " addr"}, bus.imem_addr_o, vecs[k].e_addr);
      check({vecs[k].name, " valid"}, 32'(bus.instr_valid_o), 32'(vecs[k].e_valid));
      check({vecs[k].name, " pc"}, bus.pc_o, vecs[k].e_pc);
      check({vecs[k].name, " pc4"}, bus.pc_plus4_o, vecs[k].e_pc + 32'd4);
      check({vecs[k].name, " instr"}, bus.instr_o, vecs[k].e_instr);
    end

    // Redirect, response and pop all in one cycle.
    do_reset();
    drive(0, 0, 1, 0, 0);
    @(negedge clk); drive(0, 0, 1, 0, 0);
    check("sim_s0 addr", bus.imem_addr_o, 32'h0);
    @(negedge clk); drive(1, w(0), 1, 0, 0);
    @(negedge clk); drive(1, w(4), 1, 1, 32'h103);
    check("sim_s2 valid", 32'(bus.instr_valid_o), 32'd1);
    check("sim_s2 req", 32'(bus.imem_req_o), 32'd0);
    @(negedge clk); drive(0, 0, 1, 0, 0);
    check("sim_s3 valid", 32'(bus.instr_valid_o), 32'd0);
    check("sim_s3 req", 32'(bus.imem_req_o), 32'd1);
    check("sim_s3 addr", bus.imem_addr_o, 32'h100);
    check("sim_s3 pc hold", bus.pc_o, 32'h0);
    @(negedge clk); drive(1, w(32'h100), 1, 0, 0);
    check("sim_s4 addr", bus.imem_addr_o, 32'h104);
    @(negedge clk); drive(0, 0, 1, 0, 0);
    check("sim_s5 pc", bus.pc_o, 32'h100);
    check("sim_s5 instr", bus.instr_o, w(32'h100));

    // Fetch address wraps past the top of memory.
    do_reset();
    drive(0, 0, 1, 0, 0);
    @(negedge clk); drive(0, 0, 1, 1, 32'hFFFF_FFFC);
    check("wrap_w0 req", 32'(bus.imem_req_o), 32'd0);
    @(negedge clk); drive(0, 0, 1, 0, 0);
    check("wrap_w1 addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    @(negedge clk); drive(1, w(32'hFFFF_FFFC), 1, 0, 0);
    check("wrap_w2 req", 32'(bus.imem_req_o), 32'd1);
    check("wrap_w2 addr", bus.imem_addr_o, 32'h0);
    @(negedge clk); drive(1, w(0), 1, 0, 0);
    check("wrap_w3 pc", bus.pc_o, 32'hFFFF_FFFC);
    check("wrap_w3 pc4", bus.pc_plus4_o, 32'h0);
    check("wrap_w3 instr", bus.instr_o, w(32'hFFFF_FFFC));
    @(negedge clk); drive(0, 0, 1, 0, 0);
    check("wrap_w4 pc", bus.pc_o, 32'h0);
    check("wrap_w4 pc4", bus.pc_plus4_o, 32'h4);

    // Asynchronous reset with a full queue and a request going out.
    do_reset();
    drive(0, 0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0);
    @(negedge clk); drive(1, w(0), 0, 0, 0);
    @(negedge clk); drive(1, w(4), 0, 0, 0);
    @(negedge clk); drive(0, 0, 1, 0, 0);
    check("mid req before", 32'(bus.imem_req_o), 32'd1);
    check("mid addr before", bus.imem_addr_o, 32'h8);
    rst_n = 1'b0;
    #1;
    check("mid rst req", 32'(bus.imem_req_o), 32'd0);
    check("mid rst addr", bus.imem_addr_o, 32'h0);
    check("mid rst valid", 32'(bus.instr_valid_o), 32'd0);
    check("mid rst pc", bus.pc_o, 32'h0);
    check("mid rst pc4", bus.pc_plus4_o, 32'h4);
    check("mid rst instr", bus.instr_o, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 1, 0, 0);
    check("mid rel req", 32'(bus.imem_req_o), 32'd0);
    @(negedge clk); drive(0, 0, 1, 0, 0);
    check("mid first req", 32'(bus.imem_req_o), 32'd1);
    check("mid first addr", bus.imem_addr_o, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
